// File: rtl/mram_bist_engine.sv
// rtl/mram_bist_engine.sv - self-checking write/read-back traffic engine for the simple dual-port MRAM
//
// Purpose:
//   On an accepted start the engine writes a mode-selected pattern to every
//   RAM address, reads every address back, and compares each returned word
//   with the pattern value. At the end it pulses o_done, reports o_pass and
//   holds the saturating mismatch count on o_err_cnt.
//
// Optional feature (macro MRAM_BIST_ERRLOG_EN):
//   When defined, the address and read data of the first mismatch of a run
//   are captured on o_first_err_vld / o_first_err_addr / o_first_err_data.
//   When undefined, those ports and registers do not exist.
//
// Ports:
//   i_clk            clock shared with both RAM ports
//   i_rst_n          asynchronous active-low reset
//   i_start          run request, only honoured in IDLE
//   i_mode           pattern select, latched with an accepted start
//   i_seed           pattern seed, latched with an accepted start
//   o_wr_en          RAM write enable
//   o_wraddr         RAM write address
//   o_wrdata         RAM write data
//   o_rd_en          RAM read enable
//   o_rdaddr         RAM read address
//   i_rddata         RAM read data, valid RD_LAT cycles after o_rd_en
//   o_busy           high while writing, reading or draining
//   o_done           one-cycle end-of-run pulse
//   o_pass           no mismatches in the last completed run
//   o_err_cnt        saturating mismatch count
//   o_first_err_*    first-mismatch log (MRAM_BIST_ERRLOG_EN only)

module mram_bist_engine #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int RD_LAT = 1
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_start,
    input  logic [1:0]        i_mode,
    input  logic [DATA_W-1:0] i_seed,
    output logic              o_wr_en,
    output logic [ADDR_W-1:0] o_wraddr,
    output logic [DATA_W-1:0] o_wrdata,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rdaddr,
    input  logic [DATA_W-1:0] i_rddata,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [15:0]       o_err_cnt
`ifdef MRAM_BIST_ERRLOG_EN
    ,
    output logic              o_first_err_vld,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic [DATA_W-1:0] o_first_err_data
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WRITE,
        S_READ,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [ADDR_W-1:0] LP_ADDR_LAST  = '1;
    localparam logic [2:0]        LP_DRAIN_LAST = 3'(RD_LAT - 1);
    localparam logic [15:0]       LP_ERR_MAX    = 16'hFFFF;

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_addr;
    logic [2:0]          r_drain_cnt;
    logic [1:0]          r_mode;
    logic [DATA_W-1:0]   r_seed;
    logic [15:0]         r_err;
    logic                r_pass;

    // Expected-data pipeline: one stage per cycle of RAM read latency, so the
    // last stage lines up with the rddata belonging to the same rd_en.
    logic                r_vld [RD_LAT];
    logic [DATA_W-1:0]   r_exp [RD_LAT];

    logic                w_accept;
    logic                w_mismatch;

`ifdef MRAM_BIST_ERRLOG_EN
    logic [ADDR_W-1:0]   r_eaddr [RD_LAT];
    logic                r_first_vld;
    logic [ADDR_W-1:0]   r_first_addr;
    logic [DATA_W-1:0]   r_first_data;

    assign o_first_err_vld  = r_first_vld;
    assign o_first_err_addr = r_first_addr;
    assign o_first_err_data = r_first_data;
`endif

    function automatic logic [DATA_W-1:0] f_pattern(
        input logic [1:0]        mode,
        input logic [DATA_W-1:0] seed,
        input logic [ADDR_W-1:0] addr
    );
        logic [DATA_W-1:0] w_a;
        logic [DATA_W-1:0] w_one;
        logic [DATA_W-1:0] w_res;
        w_a   = DATA_W'(addr);
        w_one = DATA_W'(1);
        case (mode)
            2'd0:    w_res = seed + w_a;
            2'd1:    w_res = w_a;
            2'd2:    w_res = w_one << (32'(addr) % DATA_W);
            default: w_res = ~(seed + w_a);
        endcase
        return w_res;
    endfunction

    assign w_accept   = (r_state == S_IDLE) && i_start;
    assign w_mismatch = r_vld[RD_LAT-1] && (i_rddata != r_exp[RD_LAT-1]);
    assign o_err_cnt  = r_err;

    always_comb begin
        w_next   = r_state;
        o_wr_en  = 1'b0;
        o_wraddr = '0;
        o_wrdata = '0;
        o_rd_en  = 1'b0;
        o_rdaddr = '0;
        o_busy   = 1'b0;
        o_done   = 1'b0;
        o_pass   = r_pass;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_WRITE;
                end
            end
            S_WRITE: begin
                o_wr_en  = 1'b1;
                o_wraddr = r_addr;
                o_wrdata = f_pattern(r_mode, r_seed, r_addr);
                o_busy   = 1'b1;
                if (r_addr == LP_ADDR_LAST) begin
                    w_next = S_READ;
                end
            end
            S_READ: begin
                o_rd_en  = 1'b1;
                o_rdaddr = r_addr;
                o_busy   = 1'b1;
                if (r_addr == LP_ADDR_LAST) begin
                    w_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                o_busy = 1'b1;
                if (r_drain_cnt == LP_DRAIN_LAST) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                // err_cnt already holds the final compare here, so pass is
                // presented together with the done pulse.
                o_pass = (r_err == 16'd0);
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_drain_cnt <= '0;
            r_mode      <= '0;
            r_seed      <= '0;
            r_err       <= '0;
            r_pass      <= 1'b0;
            for (int i = 0; i < RD_LAT; i++) begin
                r_vld[i] <= 1'b0;
                r_exp[i] <= '0;
            end
`ifdef MRAM_BIST_ERRLOG_EN
            for (int i = 0; i < RD_LAT; i++) begin
                r_eaddr[i] <= '0;
            end
            r_first_vld  <= 1'b0;
            r_first_addr <= '0;
            r_first_data <= '0;
`endif
        end else begin
            r_state <= w_next;

            // One address counter serves both phases; it restarts from 0 on
            // every state change so each phase covers the whole array.
            if (r_state != w_next) begin
                r_addr <= '0;
            end else if ((r_state == S_WRITE) || (r_state == S_READ)) begin
                r_addr <= r_addr + 1'b1;
            end

            if (r_state == S_DRAIN) begin
                r_drain_cnt <= r_drain_cnt + 3'd1;
            end else begin
                r_drain_cnt <= '0;
            end

            r_vld[0] <= (r_state == S_READ);
            r_exp[0] <= f_pattern(r_mode, r_seed, r_addr);
            for (int i = 1; i < RD_LAT; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_exp[i] <= r_exp[i-1];
            end

            if (w_mismatch && (r_err != LP_ERR_MAX)) begin
                r_err <= r_err + 16'd1;
            end

            if (r_state == S_DONE) begin
                r_pass <= (r_err == 16'd0);
            end

`ifdef MRAM_BIST_ERRLOG_EN
            r_eaddr[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_eaddr[i] <= r_eaddr[i-1];
            end
            if (w_mismatch && !r_first_vld) begin
                r_first_vld  <= 1'b1;
                r_first_addr <= r_eaddr[RD_LAT-1];
                r_first_data <= i_rddata;
            end
`endif

            // An accepted start overrides everything left from the last run.
            if (w_accept) begin
                r_mode <= i_mode;
                r_seed <= i_seed;
                r_err  <= '0;
                r_pass <= 1'b0;
`ifdef MRAM_BIST_ERRLOG_EN
                r_first_vld  <= 1'b0;
                r_first_addr <= '0;
                r_first_data <= '0;
`endif
            end
        end
    end

endmodule

// File: tb/tb_mram_bist_engine.sv
// tb/tb_mram_bist_engine.sv - bench for mram_bist_engine at RD_LAT=1 and RD_LAT=3 with ideal RAM models
module tb_mram_bist_engine;

    localparam int D      = 16;
    localparam int CORR_A = 7;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [31:0] seed = 32'd0;
    bit          corrupt = 1'b0;

    always #5 clk = ~clk;

    logic        wr_en_v [2];
    logic        rd_en_v [2];
    logic        busy_v  [2];
    logic        done_v  [2];
    logic        pass_v  [2];
    logic [3:0]  wraddr_v [2];
    logic [3:0]  rdaddr_v [2];
    logic [31:0] wrdata_v [2];
    logic [31:0] rddata_v [2];
    logic [15:0] err_v [2];

`ifdef MRAM_BIST_ERRLOG_EN
    logic        fe_vld_v  [2];
    logic [3:0]  fe_addr_v [2];
    logic [31:0] fe_data_v [2];
`endif

    mram_bist_engine #(.DATA_W(32), .ADDR_W(4), .RD_LAT(1)) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_seed(seed),
        .o_wr_en(wr_en_v[0]), .o_wraddr(wraddr_v[0]), .o_wrdata(wrdata_v[0]),
        .o_rd_en(rd_en_v[0]), .o_rdaddr(rdaddr_v[0]), .i_rddata(rddata_v[0]),
        .o_busy(busy_v[0]), .o_done(done_v[0]), .o_pass(pass_v[0]), .o_err_cnt(err_v[0])
`ifdef MRAM_BIST_ERRLOG_EN
        , .o_first_err_vld(fe_vld_v[0]), .o_first_err_addr(fe_addr_v[0]), .o_first_err_data(fe_data_v[0])
`endif
    );

    mram_bist_engine #(.DATA_W(32), .ADDR_W(4), .RD_LAT(3)) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_mode(mode), .i_seed(seed),
        .o_wr_en(wr_en_v[1]), .o_wraddr(wraddr_v[1]), .o_wrdata(wrdata_v[1]),
        .o_rd_en(rd_en_v[1]), .o_rdaddr(rdaddr_v[1]), .i_rddata(rddata_v[1]),
        .o_busy(busy_v[1]), .o_done(done_v[1]), .o_pass(pass_v[1]), .o_err_cnt(err_v[1])
`ifdef MRAM_BIST_ERRLOG_EN
        , .o_first_err_vld(fe_vld_v[1]), .o_first_err_addr(fe_addr_v[1]), .o_first_err_data(fe_data_v[1])
`endif
    );

    // Ideal RAMs; rddata is garbage whenever no read is returning, so any
    // compare made too early shows up as a mismatch.
    logic [31:0] mem0 [D];
    logic [31:0] mem1 [D];
    logic [31:0] pd0;
    logic        pv0;
    logic [31:0] pd1 [3];
    logic        pv1 [3];

    always @(posedge clk) begin
        if (wr_en_v[0]) mem0[wraddr_v[0]] <= wrdata_v[0];
        if (wr_en_v[1]) mem1[wraddr_v[1]] <= wrdata_v[1];
        pv0 <= rd_en_v[0];
        pd0 <= mem0[rdaddr_v[0]] ^ ((corrupt && rdaddr_v[0] == 4'(CORR_A)) ? 32'h1 : 32'h0);
        pv1[0] <= rd_en_v[1];
        pd1[0] <= mem1[rdaddr_v[1]] ^ ((corrupt && rdaddr_v[1] == 4'(CORR_A)) ? 32'h1 : 32'h0);
        pv1[1] <= pv1[0];
        pd1[1] <= pd1[0];
        pv1[2] <= pv1[1];
        pd1[2] <= pd1[1];
    end

    assign rddata_v[0] = pv0 ? pd0 : 32'hDEADBEEF;
    assign rddata_v[1] = pv1[2] ? pd1[2] : 32'hDEADBEEF;

    // Timeline model: t counts cycles since the accepting edge (0 = idle).
    int          t_m    [2];
    logic [1:0]  md_m   [2];
    logic [31:0] sd_m   [2];
    bit          cr_m   [2];
    int          err_h  [2];
    bit          pass_h [2];

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic int done_t(input int i);
        return 2 * D + lat_of(i) + 1;
    endfunction

    function automatic int err_at(input int i, input int t, input bit cr);
        return (cr && t >= D + 2 + CORR_A + lat_of(i)) ? 1 : 0;
    endfunction

    function automatic logic [31:0] pat(input logic [1:0] m, input logic [31:0] s, input int a);
        case (m)
            2'd0:    return s + 32'(a);
            2'd1:    return 32'(a);
            2'd2:    return 32'h1 << (a % 32);
            default: return ~(s + 32'(a));
        endcase
    endfunction

    always @(posedge clk or negedge rst_n) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst_n) begin
                t_m[i]    <= 0;
                md_m[i]   <= 2'd0;
                sd_m[i]   <= 32'd0;
                cr_m[i]   <= 1'b0;
                err_h[i]  <= 0;
                pass_h[i] <= 1'b0;
            end else if (t_m[i] == 0) begin
                if (start) begin
                    t_m[i]    <= 1;
                    md_m[i]   <= mode;
                    sd_m[i]   <= seed;
                    cr_m[i]   <= corrupt;
                    err_h[i]  <= 0;
                    pass_h[i] <= 1'b0;
                end
            end else if (t_m[i] == done_t(i)) begin
                t_m[i]    <= 0;
                err_h[i]  <= err_at(i, done_t(i), cr_m[i]);
                pass_h[i] <= (err_at(i, done_t(i), cr_m[i]) == 0);
            end else begin
                t_m[i] <= t_m[i] + 1;
            end
        end
    end

    int total = 0;
    int bad = 0;
    int dcnt [2] = '{0, 0};
    logic [31:0] wseen [D];

    task automatic chk(input string nm, input int inst, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] got=%0h want=%0h", nm, inst, act, exp);
        end
    endtask

    task automatic compare_all();
        for (int i = 0; i < 2; i++) begin
            int  t;
            bit  we, re, by, dn, ps;
            int  ec;
            t  = t_m[i];
            we = (t >= 1) && (t <= D);
            re = (t >= D + 1) && (t <= 2 * D);
            by = (t >= 1) && (t <= 2 * D + lat_of(i));
            dn = (t == done_t(i));
            ec = (t > 0) ? err_at(i, t, cr_m[i]) : err_h[i];
            ps = dn ? (ec == 0) : pass_h[i];
            chk("wr_en", i, 64'(wr_en_v[i]), 64'(we));
            chk("wraddr", i, 64'(wraddr_v[i]), we ? 64'(t - 1) : 64'd0);
            chk("wrdata", i, 64'(wrdata_v[i]), we ? 64'(pat(md_m[i], sd_m[i], t - 1)) : 64'd0);
            chk("rd_en", i, 64'(rd_en_v[i]), 64'(re));
            chk("rdaddr", i, 64'(rdaddr_v[i]), re ? 64'(t - D - 1) : 64'd0);
            chk("busy", i, 64'(busy_v[i]), 64'(by));
            chk("done", i, 64'(done_v[i]), 64'(dn));
            chk("err_cnt", i, 64'(err_v[i]), 64'(ec));
            chk("pass", i, 64'(pass_v[i]), 64'(ps));
            if (done_v[i]) dcnt[i]++;
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_all();
    endtask

    task automatic run(input logic [1:0] m, input logic [31:0] s, input bit corr, input bit inject,
                       output int l0, output int l1);
        int n;
        mode = m;
        seed = s;
        corrupt = corr;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 1;
        l0 = -1;
        l1 = -1;
        while ((l0 < 0 || l1 < 0) && n < 100) begin
            if (done_v[0] && l0 < 0) l0 = n;
            if (done_v[1] && l1 < 0) l1 = n;
            if (wr_en_v[0]) wseen[wraddr_v[0]] = wrdata_v[0];
            start = inject && (n == 3 || n == 20);
            if (inject && n == 10) begin
                mode = ~m;
                seed = ~s;
            end
            tick();
            n++;
        end
        start = 1'b0;
        tick();
    endtask

    initial begin
        int l0, l1, d0, d1, n;
        tick();
        chk("rst_wr_en", 0, 64'(wr_en_v[0]), 64'd0);
        chk("rst_busy", 1, 64'(busy_v[1]), 64'd0);
        chk("rst_err", 0, 64'(err_v[0]), 64'd0);
        chk("rst_pass", 1, 64'(pass_v[1]), 64'd0);
        rst_n = 1'b1;
        tick();

        run(2'd0, 32'h100, 1'b0, 1'b0, l0, l1);
        chk("lat_done", 0, 64'(l0), 64'd34);
        chk("lat_done", 1, 64'(l1), 64'd36);
        chk("m0_wr0", 0, 64'(wseen[0]), 64'h100);
        chk("m0_wr15", 0, 64'(wseen[15]), 64'h10F);
        chk("m0_pass", 0, 64'(pass_v[0]), 64'd1);
        chk("m0_err", 1, 64'(err_v[1]), 64'd0);

        run(2'd2, 32'h0, 1'b0, 1'b0, l0, l1);
        chk("m2_wr5", 0, 64'(wseen[5]), 64'h20);
        chk("m2_pass", 1, 64'(pass_v[1]), 64'd1);

        run(2'd3, 32'h0, 1'b0, 1'b0, l0, l1);
        chk("m3_wr0", 0, 64'(wseen[0]), 64'hFFFFFFFF);
        chk("m3_pass", 0, 64'(pass_v[0]), 64'd1);

        run(2'd1, 32'h0, 1'b1, 1'b0, l0, l1);
        chk("corr_lat", 1, 64'(l1), 64'd36);
        chk("corr_err", 0, 64'(err_v[0]), 64'd1);
        chk("corr_err", 1, 64'(err_v[1]), 64'd1);
        chk("corr_pass", 0, 64'(pass_v[0]), 64'd0);
        chk("corr_pass", 1, 64'(pass_v[1]), 64'd0);
`ifdef MRAM_BIST_ERRLOG_EN
        chk("fe_vld", 0, 64'(fe_vld_v[0]), 64'd1);
        chk("fe_addr", 0, 64'(fe_addr_v[0]), 64'd7);
        chk("fe_addr", 1, 64'(fe_addr_v[1]), 64'd7);
        chk("fe_data", 1, 64'(fe_data_v[1]), 64'd6);
`endif
        corrupt = 1'b0;

        d0 = dcnt[0];
        d1 = dcnt[1];
        run(2'd0, 32'hA5A50000, 1'b0, 1'b1, l0, l1);
        tick();
        tick();
        chk("inj_dones", 0, 64'(dcnt[0] - d0), 64'd1);
        chk("inj_dones", 1, 64'(dcnt[1] - d1), 64'd1);
        chk("inj_lat", 0, 64'(l0), 64'd34);
        chk("inj_err", 0, 64'(err_v[0]), 64'd0);
        chk("inj_pass", 1, 64'(pass_v[1]), 64'd1);
`ifdef MRAM_BIST_ERRLOG_EN
        chk("inj_fe_vld", 0, 64'(fe_vld_v[0]), 64'd0);
`endif

        mode = 2'd0;
        seed = 32'h55;
        start = 1'b1;
        tick();
        start = 1'b0;
        n = 0;
        while (!(rd_en_v[0] && rdaddr_v[0] == 4'd9) && n < 60) begin
            tick();
            n++;
        end
        chk("rst_reach_rd9", 0, 64'(rdaddr_v[0]), 64'd9);
        d0 = dcnt[0];
        d1 = dcnt[1];
        #2 rst_n = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk("midrst_wr_en", i, 64'(wr_en_v[i]), 64'd0);
            chk("midrst_rd_en", i, 64'(rd_en_v[i]), 64'd0);
            chk("midrst_busy", i, 64'(busy_v[i]), 64'd0);
        end
        tick();
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) tick();
        chk("midrst_nodone", 0, 64'(dcnt[0] - d0), 64'd0);
        chk("midrst_nodone", 1, 64'(dcnt[1] - d1), 64'd0);

        run(2'd0, 32'h55, 1'b0, 1'b0, l0, l1);
        chk("post_lat", 0, 64'(l0), 64'd34);
        chk("post_lat", 1, 64'(l1), 64'd36);
        chk("post_pass", 0, 64'(pass_v[0]), 64'd1);
        chk("post_err", 1, 64'(err_v[1]), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule
